// File: rtl/wb_arbiter_pkg.sv
// Shared types for the writeback arbiter: per-channel select bits and FSM states.
package wb_pkg;

    localparam int SEL_PC = 2;
    localparam int SEL_WR = 1;
    localparam int SEL_F  = 0;

    typedef struct packed {
        logic pc_update;
        logic reg_write;
        logic fmode;
    } wb_sel_t;

    typedef enum logic {
        RUN    = 1'b0,
        SETTLE = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_arbiter_rr.sv
// Round-robin arbiter: grants the first requester at or after the pointer;
// the pointer moves past the winner only when the grant is consumed.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 enable,
    input  logic                 advance,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic          found;

    // Two passes: indices at/after the pointer first, then the wrapped-around range.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (enable && !found && req[i] && (IW'(i) >= ptr_q)) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
            end
        end
        for (int unsigned i = 0; i < N; i++) begin
            if (enable && !found && req[i]) begin
                found     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = IW'(i);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: NUM_CH completion sources share one register write port and
// one PC-redirect port. Optional macro WB_BYPASS_EN adds combinational forwarding outputs.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int XLEN   = 32,
    parameter int REG_W  = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [3*NUM_CH-1:0]     req_sel,
    input  logic [XLEN*NUM_CH-1:0]  req_pc,
    input  logic [XLEN*NUM_CH-1:0]  req_data,
    input  logic [REG_W*NUM_CH-1:0] req_rd,
    output logic [NUM_CH-1:0]       done,
    output logic                    wenable,
    output logic                    fmode,
    output logic [REG_W-1:0]        wreg,
    output logic [XLEN-1:0]         wdata,
    output logic                    pcenable,
    output logic [XLEN-1:0]         next_pc
`ifdef WB_BYPASS_EN
    ,
    output logic                    byp_valid,
    output logic                    byp_fmode,
    output logic [REG_W-1:0]        byp_rd,
    output logic [XLEN-1:0]         byp_data
`endif
);

    localparam int IW = $clog2(NUM_CH);

    wb_state_e         state_q, state_d;
    logic [NUM_CH-1:0] grant;
    logic [IW-1:0]     grant_idx;
    logic              xfer;
    wb_sel_t           g_sel;
    logic [XLEN-1:0]   g_pc, g_data;
    logic [REG_W-1:0]  g_rd;
    logic              g_we;

    logic [NUM_CH-1:0] done_q, done_d, pend_q, pend_d;
    logic              we_q, we_d, f_q, f_d, pce_q, pce_d;
    logic [REG_W-1:0]  wreg_q, wreg_d;
    logic [XLEN-1:0]   wdata_q, wdata_d, npc_q, npc_d;

    rr_arbiter #(.N(NUM_CH)) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .enable    (state_q == RUN),
        .advance   (xfer),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign xfer      = |grant;

    always_comb begin
        g_sel  = '0;
        g_pc   = '0;
        g_data = '0;
        g_rd   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant_idx == IW'(i)) begin
                g_sel  = wb_sel_t'(req_sel[3*i +: 3]);
                g_pc   = req_pc[XLEN*i +: XLEN];
                g_data = req_data[XLEN*i +: XLEN];
                g_rd   = req_rd[REG_W*i +: REG_W];
            end
        end
    end

    // Integer x0 is never written; float f0 is a real register.
    assign g_we = xfer & g_sel.reg_write & ~((g_rd == '0) & ~g_sel.fmode);

    always_comb begin
        state_d = state_q;
        done_d  = '0;
        pend_d  = pend_q;
        we_d    = 1'b0;
        pce_d   = 1'b0;
        f_d     = f_q;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        npc_d   = npc_q;
        case (state_q)
            RUN: begin
                if (xfer) begin
                    we_d    = g_we;
                    f_d     = g_sel.fmode;
                    wreg_d  = g_rd;
                    wdata_d = g_data;
                    pce_d   = g_sel.pc_update;
                    npc_d   = g_pc;
                    if (g_sel.pc_update) begin
                        state_d = SETTLE;
                        pend_d  = grant;
                    end else begin
                        done_d  = grant;
                    end
                end
            end
            SETTLE: begin
                done_d  = pend_q;
                pend_d  = '0;
                state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            done_q  <= '0;
            pend_q  <= '0;
            we_q    <= 1'b0;
            f_q     <= 1'b0;
            pce_q   <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            pend_q  <= pend_d;
            we_q    <= we_d;
            f_q     <= f_d;
            pce_q   <= pce_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            npc_q   <= npc_d;
        end
    end

    assign done     = done_q;
    assign wenable  = we_q;
    assign fmode    = f_q;
    assign wreg     = wreg_q;
    assign wdata    = wdata_q;
    assign pcenable = pce_q;
    assign next_pc  = npc_q;

`ifdef WB_BYPASS_EN
    assign byp_valid = g_we;
    assign byp_fmode = g_sel.fmode;
    assign byp_rd    = g_rd;
    assign byp_data  = g_data;
`endif

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Parametrised writeback stage with NUM_CH completion sources (e.g. ALU, FPU, load unit) sharing one register-file write port and one PC-redirect port.
- Each source offers one result through a valid/ready handshake.
- The block arbitrates round-robin, registers the winning write, and pulses a per-channel done.
- Sits between the execute/memory units and the int/float register files plus fetch PC logic.

Parameters:
- NUM_CH, 3, number of completion channels (2..8).
- XLEN, 32, data and PC width.
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_CH  channel i has a result.
- req_ready  out  NUM_CH  one-hot grant; transfer when valid&ready (combinational from valid, state, pointer).
- req_sel  in  3*NUM_CH  per channel {pc_update, reg_write, fmode}, bits [3i+2:3i].
- req_pc  in  XLEN*NUM_CH  redirect target.
- req_data  in  XLEN*NUM_CH  writeback data.
- req_rd  in  REG_W*NUM_CH  destination register.
- done  out  NUM_CH  one-cycle completion pulse per channel.
- wenable  out  1  register-file write strobe.
- fmode  out  1  1 selects float register file.
- wreg  out  REG_W  write index.
- wdata  out  XLEN  write data.
- pcenable  out  1  one-cycle PC redirect strobe.
- next_pc  out  XLEN  redirect target.

Behaviour:
Reset:
- All outputs 0; rr pointer = 0; FSM = RUN.
- Reset mid-operation drops any pending done or redirect. No done is issued for an accepted request whose done is still outstanding.

FSM states RUN and SETTLE:
- RUN:
  - Grant the first valid channel at or after the pointer, wrapping modulo NUM_CH.
  - On a transfer at cycle T, the pointer becomes grant index+1 (wrap NUM_CH-1 -> 0).
  - If no channel is valid, the pointer is held.
- At T+1, registered outputs take the granted request:
  - wenable = reg_write & ~(rd==0 & ~fmode). Integer x0 writes are suppressed; float f0 is writable.
  - fmode, wreg, wdata are copied.
  - pcenable = pc_update; next_pc = pc.
- Non-redirect completion, pc_update=0 (includes sel=000):
  - done[i] pulses at T+1.
  - Stay in RUN; a new grant is allowed at T+1 (throughput 1/cycle).
- Redirect completion, pc_update=1:
  - Go to SETTLE at T+1.
  - done[i] pulses at T+2.
  - req_ready = 0 during SETTLE.
  - Return to RUN at T+2.
- Strobes:
  - wenable and pcenable are single-cycle strobes: 0 on any cycle without a fresh transfer.
  - wreg, wdata and next_pc hold their last values.
- Simultaneous events:
  - A valid dropped without ready is legal; the pointer is unaffected.
  - At most one done bit is high per cycle.
  - The done for a SETTLE request and the done for a RUN grant never coincide, because there is no grant during SETTLE.
- Data inputs of a non-granted channel are don't-care.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined, add outputs byp_valid (1), byp_fmode (1), byp_rd (REG_W), byp_data (XLEN).
  - These are combinational copies of the request being transferred this cycle.
  - byp_valid = transfer & reg_write & ~(rd==0 & ~fmode).
  - They let decode forward one cycle earlier.
- When undefined, the ports do not exist and timing is unchanged.

Decomposition:
- Package wb_pkg:
  - SEL_PC=2, SEL_WR=1, SEL_F=0 bit-position constants.
  - typedef wb_sel_t (3-bit packed struct).
  - FSM state enum {RUN, SETTLE}.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req, enable, advance.
  - Outputs: one-hot grant, grant_idx.
  - Owns the pointer.
- The top module holds the FSM, output registers and done logic.

Test Plan:
1. Reset, then idle 5 cycles -> all outputs 0. Then ch0 sends sel=010, rd=3, data=0xDEADBEEF -> next cycle wenable=1, wreg=3, wdata=0xDEADBEEF, done=001.
2. ch0, ch1, ch2 all valid with sel=010 continuously -> grants in order 0,1,2,0; one done per cycle; 4 writes in 4 consecutive cycles.
3. ch1 sel=110, pc=0x100, rd=5 -> T+1: pcenable=1, next_pc=0x100, wenable=1; req_ready=000 at T+1 while ch2 is valid; done=010 at T+2; ch2 granted at T+2.
4. ch2 sel=010, rd=0 -> wenable=0, done=100. Then sel=011, rd=0 -> wenable=1, fmode=1, wreg=0.
5. ch0 sel=000 -> done=001 at T+1, no strobes. Assert rst during SETTLE after a redirect -> no done pulse; next cycle all outputs 0 and pointer=0.
6. With WB_BYPASS_EN: ch1 sel=010, rd=7, data=0x42 -> in the transfer cycle byp_valid=1, byp_rd=7, byp_data=0x42; byp_valid=0 for a rd=0 integer write.
